// File: rtl/serial_parallel_loader.sv
// serial_parallel_loader: collects NUM_ELEM elements of ELEM_W bits from an
// IN_W-bit valid/ready beat stream and publishes them together through a
// shadow register, so the consumer never sees a partially loaded set.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      begin a load (sampled only while idle)
//   abort      drop an in-progress load (no effect when not loading)
//   in_valid   serial_in carries a beat
//   serial_in  IN_W-bit beat
//   in_ready   beat accepted this cycle when in_valid is also high
//   busy       load or publish in progress
//   done       one-cycle pulse: elem_out holds a fresh complete set
//   elem_out   element k at [k*ELEM_W +: ELEM_W], element 0 received first
module serial_parallel_loader #(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned ELEM_W    = 16,
  parameter int unsigned NUM_ELEM  = 9,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         in_valid,
  input  logic [IN_W-1:0]              serial_in,
  output logic                         in_ready,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_ELEM*ELEM_W-1:0]   elem_out
);

  localparam int unsigned BEATS = ELEM_W / IN_W;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned KW    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam int unsigned OUT_W = NUM_ELEM * ELEM_W;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [KW-1:0] LAST_ELEM = KW'(NUM_ELEM - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [BW-1:0]   beat_cnt;
  logic [KW-1:0]   elem_cnt;
  logic [ELEM_W-1:0] acc;
  logic [OUT_W-1:0]  shadow;

  logic [BW-1:0]     beat_pos_c;
  logic [ELEM_W-1:0] acc_c;
  logic              accept_c;

  // Element being assembled with the current beat merged into its slot;
  // abort wins over acceptance, and in_ready already implies LOAD.
  always_comb begin
    accept_c   = in_valid & in_ready & ~abort;
    beat_pos_c = MSB_FIRST ? (LAST_BEAT - beat_cnt) : beat_cnt;
    acc_c      = acc;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (beat_pos_c == BW'(b)) begin
        acc_c[b*IN_W +: IN_W] = serial_in;
      end
    end
  end

  // Load sequencer with registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      elem_out <= '0;
      shadow   <= '0;
      acc      <= '0;
      beat_cnt <= '0;
      elem_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= S_LOAD;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            beat_cnt <= '0;
            elem_cnt <= '0;
            acc      <= '0;
          end
        end
        S_LOAD: begin
          if (abort) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            beat_cnt <= '0;
            elem_cnt <= '0;
            acc      <= '0;
          end else if (accept_c) begin
            if (beat_cnt == LAST_BEAT) begin
              for (int unsigned k = 0; k < NUM_ELEM; k++) begin
                if (elem_cnt == KW'(k)) begin
                  shadow[k*ELEM_W +: ELEM_W] <= acc_c;
                end
              end
              acc      <= '0;
              beat_cnt <= '0;
              if (elem_cnt == LAST_ELEM) begin
                state    <= S_DONE;
                in_ready <= 1'b0;
                elem_cnt <= '0;
              end else begin
                elem_cnt <= elem_cnt + KW'(1);
              end
            end else begin
              acc      <= acc_c;
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
        S_DONE: begin
          // Publish every slot in one edge; done lands in the first idle cycle.
          elem_out <= shadow;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule
